cnn_layer_sequencer: RTL

CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

---
 rtl/cnn_layer_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer
// Steps one frame through a chain of layer engines (index 0 first) using a
// level start / level done handshake with each engine. Every handshake phase
// is guarded by a timeout, the frame can be cancelled with abort, and the
// number of cycles spent sequencing is reported in frame_cycles.
// All outputs come straight from flops.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int CNT_WIDTH      = 32,
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  abort,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [LW-1:0]         cur_layer,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  frame_cycles
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ASSERT  = 3'd1,
    S_WAIT    = 3'd2,
    S_RELEASE = 3'd3,
    S_FINISH  = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [TW-1:0]           timer;
  logic [TW-1:0]           timer_nxt;
  logic [LW-1:0]           layer_nxt;
  logic [NUM_LAYERS-1:0]   start_nxt;
  logic                    busy_nxt;
  logic                    done_nxt;
  logic                    error_nxt;
  logic [CNT_WIDTH-1:0]    cycles_nxt;

  logic cur_done;
  logic timer_hit;
  logic last_layer;
  logic frame_active;

  // Saturating increment so a very long frame pins at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + CNT_WIDTH'(1);
  endfunction

  // Only the currently sequenced engine's done bit is ever looked at.
  assign cur_done     = layer_done[cur_layer];
  assign timer_hit    = (timer == TMO_LAST);
  assign last_layer   = (cur_layer == LAST_LAYER);
  assign frame_active = (state == S_ASSERT) || (state == S_WAIT) || (state == S_RELEASE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; abort outranks every other exit from an in-flight phase.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (run && !abort) state_nxt = S_ASSERT;
      end
      S_ASSERT: begin
        if (abort) state_nxt = S_IDLE;
        else       state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (abort)          state_nxt = S_IDLE;
        else if (cur_done)  state_nxt = S_RELEASE;
        else if (timer_hit) state_nxt = S_FAULT;
      end
      S_RELEASE: begin
        if (abort)          state_nxt = S_IDLE;
        else if (!cur_done) state_nxt = last_layer ? S_FINISH : S_ASSERT;
        else if (timer_hit) state_nxt = S_FAULT;
      end
      S_FINISH, S_FAULT: begin
        if (!run) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, layer index, phase timer and cycle count.
  always_comb begin
    layer_nxt = cur_layer;
    if ((state == S_IDLE) && (state_nxt == S_ASSERT))
      layer_nxt = '0;
    else if ((state == S_RELEASE) && (state_nxt == S_ASSERT))
      layer_nxt = cur_layer + LW'(1);

    // Timer restarts whenever a handshake phase is freshly entered.
    timer_nxt = '0;
    if ((state_nxt == S_WAIT) || (state_nxt == S_RELEASE)) begin
      if (state_nxt == state) timer_nxt = timer + TW'(1);
      else                    timer_nxt = '0;
    end

    cycles_nxt = frame_cycles;
    if ((state == S_IDLE) && (state_nxt == S_ASSERT))
      cycles_nxt = '0;
    else if (frame_active)
      cycles_nxt = sat_inc(frame_cycles);

    start_nxt = '0;
    if ((state_nxt == S_ASSERT) || (state_nxt == S_WAIT))
      start_nxt = NUM_LAYERS'(1) << layer_nxt;

    busy_nxt  = (state_nxt == S_ASSERT) || (state_nxt == S_WAIT) || (state_nxt == S_RELEASE);
    done_nxt  = (state_nxt == S_FINISH);
    error_nxt = (state_nxt == S_FAULT);
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_start  <= '0;
      cur_layer    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      frame_cycles <= '0;
      timer        <= '0;
    end else begin
      layer_start  <= start_nxt;
      cur_layer    <= layer_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      error        <= error_nxt;
      frame_cycles <= cycles_nxt;
      timer        <= timer_nxt;
    end
  end

endmodule
